// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode/funct values, ALU control codes and datapath select codes.
package mips_pkg;

  // BNEEX sits last so every other state keeps its encoding in both builds.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
`ifdef MIPS_BNE_EN
    ,BNEEX  = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the coarse aluop class plus funct onto the 3-bit ALU control code.
// funct_illegal flags an unknown funct regardless of aluop.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  logic [2:0] funct_ctrl;

  always_comb begin
    funct_ctrl    = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      F_ADD:   funct_ctrl = ALU_ADD;
      F_SUB:   funct_ctrl = ALU_SUB;
      F_AND:   funct_ctrl = ALU_AND;
      F_OR:    funct_ctrl = ALU_OR;
      F_SLT:   funct_ctrl = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default:   alucontrol = funct_ctrl;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath (lw/sw/R-type/beq/addi/j).
// Define MIPS_BNE_EN to add the bne instruction (state BNEEX).
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     cur, nxt;
  logic       is_sw;
  logic       opcode_bad;
  logic       funct_bad;
  logic       alu_used;
  logic [1:0] aluop;
  logic [2:0] dec_ctrl;

  alu_decoder u_alu_decoder (
    .aluop        (aluop),
    .funct        (funct),
    .alucontrol   (dec_ctrl),
    .funct_illegal(funct_bad)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur <= FETCH;
    else          cur <= nxt;
  end

  // opcode is only valid in DECODE, so remember lw vs sw for MEMADR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          is_sw <= 1'b0;
    else if (cur == DECODE) is_sw <= (opcode == OP_SW);
  end

  always_comb begin
    nxt        = FETCH;
    opcode_bad = 1'b0;
    case (cur)
      FETCH:   nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
`ifdef MIPS_BNE_EN
          OP_BNE:       nxt = BNEEX;
`endif
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      opcode_bad = 1'b1;
        endcase
      end
      MEMADR:  nxt = is_sw ? MEMWR : MEMRD;
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    alu_used = 1'b0;
    aluop    = ALUOP_ADD;
    alusrca  = 1'b0;
    alusrcb  = SRCB_B;
    pcsrc    = PC_ALU;
    pcen     = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    case (cur)
      FETCH: begin
        alu_used = 1'b1;
        alusrcb  = SRCB_FOUR;
        irwrite  = 1'b1;
        pcen     = 1'b1;
      end
      DECODE: begin
        alu_used = 1'b1;
        alusrcb  = SRCB_IMMSH;
      end
      MEMADR, ADDIEX: begin
        alu_used = 1'b1;
        alusrca  = 1'b1;
        alusrcb  = SRCB_IMM;
      end
      MEMRD: iord = 1'b1;
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      RTYPEEX: begin
        alu_used = 1'b1;
        aluop    = ALUOP_FUNCT;
        alusrca  = 1'b1;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      BEQEX: begin
        alu_used = 1'b1;
        aluop    = ALUOP_SUB;
        alusrca  = 1'b1;
        pcsrc    = PC_ALUOUT;
        pcen     = zero;
      end
`ifdef MIPS_BNE_EN
      BNEEX: begin
        alu_used = 1'b1;
        aluop    = ALUOP_SUB;
        alusrca  = 1'b1;
        pcsrc    = PC_ALUOUT;
        pcen     = ~zero;
      end
`endif
      JEX: begin
        pcsrc = PC_JUMP;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  assign alucontrol = alu_used ? dec_ctrl : 3'b000;
  assign illegal    = (cur == DECODE) &&
                      (opcode_bad || ((opcode == OP_RTYPE) && funct_bad));
  assign state      = cur;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: expected per-cycle output vectors
// are queued as each instruction is driven and compared once per cycle.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, illegal;
  logic [3:0] state;
  logic [19:0] obs_vec;

  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .alucontrol(alucontrol),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .pcen      (pcen),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .illegal   (illegal),
    .state     (state)
  );

  assign obs_vec = {state, alucontrol, alusrca, alusrcb, pcsrc, pcen, iord,
                    memwrite, irwrite, regdst, memtoreg, regwrite, illegal};

  // Reference output table, written from the state/output description.
  function automatic logic [19:0] exp_vec(input state_t st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z);
    logic [2:0] ac = 3'b000;
    logic       sa = 1'b0;
    logic [1:0] sb = 2'b00;
    logic [1:0] ps = 2'b00;
    logic pe = 1'b0, io = 1'b0, mw = 1'b0, iw = 1'b0;
    logic rd = 1'b0, mr = 1'b0, rw = 1'b0, il = 1'b0;
    logic fn_ok;
    fn_ok = (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
            (fn == 6'b100101) || (fn == 6'b101010);
    case (st)
      FETCH:  begin sb = 2'b01; ac = 3'b010; iw = 1'b1; pe = 1'b1; end
      DECODE: begin
        sb = 2'b11; ac = 3'b010;
        case (op)
          6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: il = 1'b0;
          6'b000000: il = !fn_ok;
`ifdef MIPS_BNE_EN
          6'b000101: il = 1'b0;
`endif
          default:   il = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin sa = 1'b1; sb = 2'b10; ac = 3'b010; end
      MEMRD:   io = 1'b1;
      MEMWR:   begin io = 1'b1; mw = 1'b1; end
      MEMWB:   begin mr = 1'b1; rw = 1'b1; end
      RTYPEEX: begin
        sa = 1'b1; sb = 2'b00;
        case (fn)
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b010;
        endcase
      end
      RTYPEWB: begin rd = 1'b1; rw = 1'b1; end
      ADDIWB:  rw = 1'b1;
      BEQEX:   begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; end
`ifdef MIPS_BNE_EN
      BNEEX:   begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = ~z; end
`endif
      JEX:     begin ps = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    return {4'(st), ac, sa, sb, ps, pe, io, mw, iw, rd, mr, rw, il};
  endfunction

  // scoreboard compare: pop one expected vector against the live outputs
  task automatic check_out(input string tag);
    logic [19:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, obs_vec);
    end else begin
      e = exp_q.pop_front();
      assert (obs_vec === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs_vec, e);
      end
    end
  endtask

  function automatic logic [19:0] seq5(input state_t a, input state_t b, input state_t c,
                                       input state_t d, input state_t e);
    return {4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // driver: called at a falling edge with the DUT in FETCH
  task automatic run_seq(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int n, input logic [19:0] seq);
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_vec(state_t'(seq[4*i +: 4]), op, fn, z));
      #1;
      check_out($sformatf("%s_c%0d", tag, i));
      @(posedge clk);
      #1;
      if (i == 1 && op != 6'b000000) opcode = 6'($urandom_range(63, 0));
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    opcode  = 6'b000000;
    funct   = 6'b000000;
    zero    = 1'b0;
    #2;
    exp_q.push_back(exp_vec(FETCH, 6'b0, 6'b0, 1'b0));
    check_out("reset_hold");
    @(negedge clk);
    reset_n = 1'b1;

    run_seq("lw",     6'b100011, 6'($urandom_range(63, 0)), 1'b0, 5,
            seq5(FETCH, DECODE, MEMADR, MEMRD, MEMWB));
    run_seq("sw",     6'b101011, 6'($urandom_range(63, 0)), 1'b1, 4,
            seq5(FETCH, DECODE, MEMADR, MEMWR, FETCH));
    run_seq("r_slt",  6'b000000, 6'b101010, 1'b0, 4,
            seq5(FETCH, DECODE, RTYPEEX, RTYPEWB, FETCH));
    run_seq("r_sub",  6'b000000, 6'b100010, 1'b1, 4,
            seq5(FETCH, DECODE, RTYPEEX, RTYPEWB, FETCH));
    run_seq("r_and",  6'b000000, 6'b100100, 1'b0, 4,
            seq5(FETCH, DECODE, RTYPEEX, RTYPEWB, FETCH));
    run_seq("r_or",   6'b000000, 6'b100101, 1'b0, 4,
            seq5(FETCH, DECODE, RTYPEEX, RTYPEWB, FETCH));
    run_seq("r_badf", 6'b000000, 6'b111111, 1'b0, 4,
            seq5(FETCH, DECODE, RTYPEEX, RTYPEWB, FETCH));
    run_seq("beq_z1", 6'b000100, 6'b0, 1'b1, 3,
            seq5(FETCH, DECODE, BEQEX, FETCH, FETCH));
    run_seq("beq_z0", 6'b000100, 6'b0, 1'b0, 3,
            seq5(FETCH, DECODE, BEQEX, FETCH, FETCH));
    run_seq("addi",   6'b001000, 6'b0, 1'b0, 4,
            seq5(FETCH, DECODE, ADDIEX, ADDIWB, FETCH));
    run_seq("j",      6'b000010, 6'b0, 1'b1, 3,
            seq5(FETCH, DECODE, JEX, FETCH, FETCH));
    run_seq("ill_op", 6'b111111, 6'b100000, 1'b0, 2,
            seq5(FETCH, DECODE, FETCH, FETCH, FETCH));
`ifdef MIPS_BNE_EN
    run_seq("bne_z0", 6'b000101, 6'b0, 1'b0, 3,
            seq5(FETCH, DECODE, BNEEX, FETCH, FETCH));
    run_seq("bne_z1", 6'b000101, 6'b0, 1'b1, 3,
            seq5(FETCH, DECODE, BNEEX, FETCH, FETCH));
`else
    run_seq("bne_ill", 6'b000101, 6'b0, 1'b0, 2,
            seq5(FETCH, DECODE, FETCH, FETCH, FETCH));
`endif

    // asynchronous reset while in RTYPEWB, observed before any clock edge
    run_seq("rst_pre", 6'b000000, 6'b101010, 1'b0, 3,
            seq5(FETCH, DECODE, RTYPEEX, FETCH, FETCH));
    exp_q.push_back(exp_vec(RTYPEWB, 6'b0, 6'b101010, 1'b0));
    #1;
    check_out("rst_pre_wb");
    reset_n = 1'b0;
    #1;
    exp_q.push_back(exp_vec(FETCH, 6'b0, 6'b0, 1'b0));
    check_out("rst_async");
    @(posedge clk);
    #1;
    exp_q.push_back(exp_vec(FETCH, 6'b0, 6'b0, 1'b0));
    check_out("rst_held_edge");
    @(negedge clk);
    reset_n = 1'b1;

    run_seq("lw_after_rst", 6'b100011, 6'b0, 1'b0, 5,
            seq5(FETCH, DECODE, MEMADR, MEMRD, MEMWB));
    exp_q.push_back(exp_vec(FETCH, 6'b0, 6'b0, 1'b0));
    #1;
    check_out("final_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
